// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: digit count, segment
// bit positions and the hex-to-gfedcba lookup table.
package seg_pkg;

    localparam int NUM_DIGITS = 32'sd8;
    localparam int SEG_DP     = 32'sd7;

    // Entry [n] is the gfedcba pattern for nibble value n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to seven-segment (gfedcba, active-high) decoder.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    // Table lookup on the current nibble.
    always_comb begin
        segs = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg_scan_drv.sv
// Eight-digit multiplexed seven-segment scan driver with per-frame snapshot,
// inter-digit blanking, leading-zero suppression and per-digit blinking.
module seg_scan_drv
    import seg_pkg::*;
#(
    parameter int DWELL      = 5,
    parameter int BLINK_HALF = 2500
) (
    input  logic        clk_10khz,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    input  logic [7:0]  blink,
    input  logic        lz_en,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_start
);

    localparam int CW = $clog2(DWELL);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [CW-1:0] C_LAST  = CW'(DWELL - 1);
    localparam logic [CW-1:0] C_ZERO  = {CW{1'b0}};
    localparam logic [BW-1:0] BC_LAST = BW'(BLINK_HALF - 1);
    localparam logic [BW-1:0] BC_ZERO = {BW{1'b0}};

    logic [2:0]    d_r;
    logic [CW-1:0] c_r;
    logic [31:0]   snap_data_r;
    logic [7:0]    snap_dp_r;
    logic [7:0]    snap_blink_r;
    logic          snap_lz_r;
    logic [BW-1:0] bc_r;
    logic          phase_r;
    logic [7:0]    an_r;
    logic [7:0]    seg_r;
    logic          frame_start_r;

    logic          frame_edge_s;
    logic [3:0]    nibble_s;
    logic [6:0]    hex_seg_s;
    logic [7:0]    lz_mask_s;
    logic [7:0]    an_nxt_s;
    logic [7:0]    seg_nxt_s;

    assign frame_edge_s = (d_r == 3'd0) && (c_r == C_ZERO);
    assign nibble_s     = snap_data_r[{d_r, 2'b00} +: 4];

    seg_hex_decode u_hex (
        .nibble (nibble_s),
        .segs   (hex_seg_s)
    );

    // Digit slot counter and digit index.
    always_ff @(posedge clk_10khz or posedge rst) begin
        if (rst) begin
            d_r <= 3'd0;
            c_r <= C_ZERO;
        end else if (c_r == C_LAST) begin
            c_r <= C_ZERO;
            d_r <= d_r + 3'd1;
        end else begin
            c_r <= c_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Frame snapshot so a frame never mixes old and new inputs.
    always_ff @(posedge clk_10khz or posedge rst) begin
        if (rst) begin
            snap_data_r  <= 32'h0000_0000;
            snap_dp_r    <= 8'h00;
            snap_blink_r <= 8'h00;
            snap_lz_r    <= 1'b0;
        end else if (frame_edge_s) begin
            snap_data_r  <= data;
            snap_dp_r    <= dp;
            snap_blink_r <= blink;
            snap_lz_r    <= lz_en;
        end
    end

    // Free-running blink half-period counter and phase.
    always_ff @(posedge clk_10khz or posedge rst) begin
        if (rst) begin
            bc_r    <= BC_ZERO;
            phase_r <= 1'b0;
        end else if (bc_r == BC_LAST) begin
            bc_r    <= BC_ZERO;
            phase_r <= ~phase_r;
        end else begin
            bc_r    <= bc_r + {{(BW-1){1'b0}}, 1'b1};
        end
    end

    // Digit k is blanked when it and every digit to its left hold zero.
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lz_mask_s = 8'h00;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run     = zero_run && (snap_data_r[4*k +: 4] == 4'h0);
            lz_mask_s[k] = zero_run;
        end
    end

    // Next output value: blank slot > blink > leading-zero > decode.
    always_comb begin
        an_nxt_s  = 8'h00;
        seg_nxt_s = 8'h00;
        if (c_r == C_ZERO) begin
            an_nxt_s  = 8'h00;
            seg_nxt_s = 8'h00;
        end else begin
            an_nxt_s = 8'h01 << d_r;
            if (phase_r && snap_blink_r[d_r]) begin
                seg_nxt_s = 8'h00;
            end else if (snap_lz_r && lz_mask_s[d_r]) begin
                seg_nxt_s         = 8'h00;
                seg_nxt_s[SEG_DP] = snap_dp_r[d_r];
            end else begin
                seg_nxt_s[6:0]    = hex_seg_s;
                seg_nxt_s[SEG_DP] = snap_dp_r[d_r];
            end
        end
    end

    // Output registers, one cycle behind the scan state.
    always_ff @(posedge clk_10khz or posedge rst) begin
        if (rst) begin
            an_r          <= 8'h00;
            seg_r         <= 8'h00;
            frame_start_r <= 1'b0;
        end else begin
            an_r          <= an_nxt_s;
            seg_r         <= seg_nxt_s;
            frame_start_r <= frame_edge_s;
        end
    end

    assign an          = an_r;
    assign seg         = seg_r;
    assign frame_start = frame_start_r;

endmodule

// File: doc/seg_scan_drv.md
# seg_scan_drv

Multiplexed eight-digit seven-segment scan driver, directly downstream of the front-panel controller. It takes the controller's 32-bit display word (eight hex nibbles), decimal-point mask and blink mask. It snapshots them once per frame and time-multiplexes them onto the board's shared segment bus and digit enables. It also provides inter-digit blanking, optional leading-zero suppression and digit blinking for the adjust cursor.

## Interface

- `DWELL`, 5: clock cycles per digit slot, including one blank cycle; legal values are 2 and above.
- `BLINK_HALF`, 2500: cycles per blink half-period, which is 0.25 s at 10 kHz.
- `clk_10khz` in 1: system tick clock.
- `rst` in 1: asynchronous, active-high reset.
- `data` in 32: display word; nibble k (`data[4k+3:4k]`) drives digit k, with digit 0 rightmost.
- `dp` in 8: decimal-point enable per digit.
- `blink` in 8: per-digit blink enable.
- `lz_en` in 1: enables leading-zero suppression.
- `an` out 8: digit enables, one-hot, active-high.
- `seg` out 8: segments, active-high; `seg[6:0]` = gfedcba, `seg[7]` = dp.
- `frame_start` out 1: one-cycle pulse at each snapshot.

## Operation

- **Scan state.**
  - Digit index `d` (3 bits, 0..7) and slot counter `c` (0..DWELL-1).
  - `c` increments every cycle. At DWELL-1 it wraps to 0 and `d` increments; `d` wraps from 7 to 0.
- **Snapshot.**
  - On the edge where state is (d=0, c=0), latch `snap_data` <= `data`, `snap_dp` <= `dp`, `snap_blink` <= `blink` and `snap_lz` <= `lz_en`.
  - Mid-frame input changes are invisible until the next frame; there is no tearing.
- **Output for state (d,c):**
  - c==0 (blank slot): `an`=0 and `seg`=0, for anti-ghosting.
  - c>=1: `an` = one-hot(d).
    - `seg[6:0]` = hex decode of `snap_data` nibble d.
    - `seg[7]` = `snap_dp[d]`.
- **Hex decode (gfedcba):** 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- **Leading-zero suppression** applies when `snap_lz`=1.
  - Digit k (k=7..1) is suppressed when nibbles k..7 of `snap_data` are all zero. Its `seg[6:0]` is forced to 0; the dp is kept.
  - Digit 0 is never suppressed.
- **Blink.**
  - Counter `bc` runs 0..BLINK_HALF-1. On wrap it toggles `phase`.
  - When `phase`=1 and `snap_blink[d]`=1, `seg` is forced to 0 (dp included). `an` is unaffected.
  - The blink counter runs independently of the scan.
- **Priority:** reset > blank slot > blink > leading-zero > normal decode.

## Timing

- **Reset values:** `an`=0, `seg`=0, `frame_start`=0, d=0, c=0, snapshot regs=0, `bc`=0, `phase`=0.
- **Latency:** `an`, `seg` and `frame_start` are registered. The outputs visible in the cycle after the edge where state is (d,c) reflect (d,c), so scan state leads the outputs by one cycle.
- **Frame:** 8·DWELL cycles, i.e. 40 cycles = 250 Hz at defaults. Each digit is lit for DWELL-1 consecutive cycles, preceded by one dark cycle.
- **First frame:** on the first edge after reset deasserts, state is (0,0).
  - Snapshot is taken.
  - `frame_start` is high for the following cycle.
  - Digit 0 lights two cycles after the first edge.
- **Mid-operation reset:** `rst` asserted mid-frame clears all state and outputs immediately (asynchronous). The scan restarts from (0,0) after release.
- **Simultaneous events:** a blink-phase toggle landing mid-digit takes effect on the next output register update; no glitch suppression is required.

## Structure

- Shared package `seg_pkg`:
  - the hex-to-segment constant table (16×7);
  - segment bit positions (`SEG_DP`=7);
  - `NUM_DIGITS`=8.
- Sub-module `seg_hex_decode`: combinational 4-bit nibble in, 7-bit gfedcba out, using the package table. It is instantiated once on the muxed nibble.
- The top module holds the counters, snapshot registers, suppression logic and output registers.

## Test plan

- **Reset release, static input.** Hold data=32'h0123_4567, dp=0, blink=0, lz_en=0. Required: `frame_start` pulses every 40 cycles. Digit 0 shows seg=8'h07 with an=8'h01 for 4 cycles after 1 dark cycle; digit 7 shows 8'h3F with an=8'h80.
- **Leading-zero suppression.** Set data=32'h0000_0A05, lz_en=1. Required: digits 7..3 have seg=0 with `an` still scanning; digit 2 = 8'h77 (A); digit 1 = 8'h3F (inner zero kept); digit 0 = 8'h6D. With data=0, only digit 0 shows 8'h3F.
- **Snapshot coherence.** Change data from 32'h1111_1111 to 32'h2222_2222 while d=3. Required: digits 3..7 of that frame still show 8'h06. The next frame shows all 8'h5B.
- **Blink.** Set blink=8'h04, dp=8'h04, data=32'h8888_8888, BLINK_HALF=2500. Required: digit 2 alternates between 8'hFF and 8'h00 every 2500 cycles; the other digits stay 8'h7F.
- **Async reset mid-frame.** Pulse rst at d=5, c=3. Required: an=0 and seg=0 in the same cycle. After release, the first lit digit is digit 0 with the newly snapshotted data.
